// File: rtl/id_ex_cond_stage.sv
// Decode-to-execute pipeline register with NZCV flag register and condition evaluation.
// Optional squashed-instruction counter enabled by defining COND_SQUASH_COUNT_EN.
module id_ex_cond_stage #(
  parameter int         DATA_W   = 32,
  parameter int         REG_W    = 4,
  parameter logic [3:0] NOP_CODE = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              MemToRegD,
  input  logic              PCSrcD,
  input  logic              BranchD,
  input  logic              PlusOneD,
  input  logic              ALUSrcD,
  input  logic [3:0]        ALUControlD,
  input  logic [1:0]        FlagWD,
  input  logic [3:0]        CondD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [REG_W-1:0]  WA3D,
  input  logic [3:0]        ALUFlags,
  output logic              RegWriteE,
  output logic              PCSrcE,
  output logic              BranchTakenE,
  output logic              MemToRegE,
  output logic              PlusOneE,
  output logic              ALUSrcE,
  output logic [3:0]        ALUControlE,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [REG_W-1:0]  WA3E,
  output logic              CondExE,
  output logic [3:0]        FlagsQ
`ifdef COND_SQUASH_COUNT_EN
  ,
  output logic [15:0]       SquashCountE
`endif
);

  localparam logic [3:0] COND_AL = 4'hE;

  logic       reg_write_p1;
  logic       pc_src_p1;
  logic       branch_p1;
  logic [1:0] flag_w_p1;
  logic [3:0] cond_p1;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    pass = z;
      4'h1:    pass = !z;
      4'h2:    pass = c;
      4'h3:    pass = !c;
      4'h4:    pass = n;
      4'h5:    pass = !n;
      4'h6:    pass = v;
      4'h7:    pass = !v;
      4'h8:    pass = c & !z;
      4'h9:    pass = !c | z;
      4'hA:    pass = (n == v);
      4'hB:    pass = (n != v);
      4'hC:    pass = !z & (n == v);
      4'hD:    pass = z | (n != v);
      4'hE:    pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

`ifdef COND_SQUASH_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction
`endif

  // D -> E boundary: a flush loads a bubble that always passes (AL) but does nothing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_p1 <= 1'b0;
      pc_src_p1    <= 1'b0;
      branch_p1    <= 1'b0;
      flag_w_p1    <= 2'b00;
      cond_p1      <= 4'h0;
      MemToRegE    <= 1'b0;
      PlusOneE     <= 1'b0;
      ALUSrcE      <= 1'b0;
      ALUControlE  <= NOP_CODE;
      SrcAE        <= '0;
      WriteDataE   <= '0;
      ExtImmE      <= '0;
      WA3E         <= '0;
    end else if (FlushE) begin
      reg_write_p1 <= 1'b0;
      pc_src_p1    <= 1'b0;
      branch_p1    <= 1'b0;
      flag_w_p1    <= 2'b00;
      cond_p1      <= COND_AL;
      MemToRegE    <= 1'b0;
      PlusOneE     <= 1'b0;
      ALUSrcE      <= 1'b0;
      ALUControlE  <= NOP_CODE;
      SrcAE        <= '0;
      WriteDataE   <= '0;
      ExtImmE      <= '0;
      WA3E         <= '0;
    end else begin
      reg_write_p1 <= RegWriteD;
      pc_src_p1    <= PCSrcD;
      branch_p1    <= BranchD;
      flag_w_p1    <= FlagWD;
      cond_p1      <= CondD;
      MemToRegE    <= MemToRegD;
      PlusOneE     <= PlusOneD;
      ALUSrcE      <= ALUSrcD;
      ALUControlE  <= ALUControlD;
      SrcAE        <= RD1D;
      WriteDataE   <= RD2D;
      ExtImmE      <= ExtImmD;
      WA3E         <= WA3D;
    end
  end

  assign CondExE      = cond_pass(cond_p1, FlagsQ);
  assign RegWriteE    = reg_write_p1 & CondExE;
  assign PCSrcE       = pc_src_p1 & CondExE;
  assign BranchTakenE = branch_p1 & CondExE;

  // Flags commit from the E-stage instruction; the D-side flush never blocks this
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      FlagsQ <= 4'b0000;
    end else begin
      if (flag_w_p1[1] & CondExE) FlagsQ[3:2] <= ALUFlags[3:2];
      if (flag_w_p1[0] & CondExE) FlagsQ[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_SQUASH_COUNT_EN
  logic vld_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      SquashCountE <= 16'd0;
    end else begin
      vld_p1 <= !FlushE;
      if (vld_p1 && !CondExE) SquashCountE <= sat_inc(SquashCountE);
    end
  end
`endif

endmodule

// File: doc/id_ex_cond_stage.md
Name: id_ex_cond_stage

Overview:
- Decode-to-execute pipeline boundary, directly downstream of the decode control unit.
- Registers decode control fields, operand data and destination register into the execute stage.
- Holds the architectural NZCV flag register and evaluates each execute-stage instruction's 4-bit condition field.
- Gates register write, branch and flag update; an instruction whose condition fails is squashed in place.

Parameters:
- DATA_W, 32, width of the operand and immediate data paths.
- REG_W, 4, width of the register-file address.
- NOP_CODE, 4'b0000, ALU control code loaded on a bubble.

Ports:
- clk  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- FlushE  in  1  loads a bubble instead of the decode inputs.
- RegWriteD  in  1  decode register-write request.
- MemToRegD  in  1  decode load select.
- PCSrcD  in  1  decode PC redirect request.
- BranchD  in  1  decode branch indicator.
- PlusOneD  in  1  decode store-plus-one indicator.
- ALUSrcD  in  1  decode immediate-operand select.
- ALUControlD  in  4  decode ALU operation.
- FlagWD  in  2  decode flag-write enables: [1] updates NZ, [0] updates CV.
- CondD  in  4  instruction condition field.
- RD1D  in  DATA_W  register operand A.
- RD2D  in  DATA_W  register operand B.
- ExtImmD  in  DATA_W  extended immediate.
- WA3D  in  REG_W  destination register.
- ALUFlags  in  4  {N,Z,C,V} produced by the execute ALU this cycle.
- RegWriteE  out  1  condition-gated register write.
- PCSrcE  out  1  condition-gated PC redirect.
- BranchTakenE  out  1  BranchE AND CondExE.
- MemToRegE  out  1  registered load select (ungated).
- PlusOneE  out  1  registered store-plus-one indicator.
- ALUSrcE  out  1  registered immediate-operand select.
- ALUControlE  out  4  registered ALU operation.
- SrcAE  out  DATA_W  registered operand A.
- WriteDataE  out  DATA_W  registered operand B.
- ExtImmE  out  DATA_W  registered immediate.
- WA3E  out  REG_W  registered destination register.
- CondExE  out  1  condition-pass indicator for the execute-stage instruction.
- FlagsQ  out  4  current architectural {N,Z,C,V}.

Behaviour:
- Reset: while reset is high, every register clears to 0 and ALUControlE loads NOP_CODE. With all enables low, all outputs read 0 except ALUControlE.
- Pipeline register:
  - Each rising edge loads all D-side fields into their E copies; latency is one cycle.
  - When FlushE=1, the edge loads a bubble instead. A bubble has every control bit 0, FlagW=0, Cond=4'hE, data fields 0, WA3=0 and ALUControl=NOP_CODE.
  - reset takes priority over FlushE.
- Condition evaluation (combinational on CondE and FlagsQ), CondExE per code:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 0 (never)
- Gating:
  - RegWriteE = RegWriteE_q & CondExE.
  - PCSrcE = PCSrcE_q & CondExE.
  - BranchTakenE = BranchE_q & CondExE.
  - Data and ALU fields are never gated.
- Flag register:
  - On a rising edge, N,Z <= ALUFlags[3:2] if FlagWE_q[1] & CondExE.
  - On a rising edge, C,V <= ALUFlags[1:0] if FlagWE_q[0] & CondExE.
  - The flag update uses the E-stage instruction. It is unaffected by FlushE in the same edge, because the instruction being flushed is the D-side one.
  - The next instruction's CondExE sees the updated flags one cycle later; no same-cycle bypass.
- Simultaneous events:
  - FlushE together with an E-stage flag-setting instruction: the flags update and the bubble enters.
  - Back-to-back flag-setting instructions each update in their own E cycle.
- Reset mid-operation clears the flags and the pipeline register immediately (asynchronous). The first post-reset E instruction evaluates against NZCV=0000.

Optional Feature:
- Macro COND_SQUASH_COUNT_EN.
- When defined:
  - Adds output SquashCountE (16 bits), reset to 0.
  - Increments on every rising edge where the E-stage instruction is not a bubble and CondExE=0.
  - Saturates at 16'hFFFF.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset high mid-stream with RegWriteD=1 -> all outputs 0 asynchronously, ALUControlE=NOP_CODE, FlagsQ=0000.
- AL instruction RegWriteD=1, WA3D=4'h3, RD1D=32'h5 -> next cycle RegWriteE=1, WA3E=3, SrcAE=5, CondExE=1.
- Flag-setting SUB with FlagWD=2'b11, ALUFlags=4'b0100 -> FlagsQ=0100 after the edge; next instruction CondD=EQ gives CondExE=1, CondD=NE gives RegWriteE=0.
- Conditional branch with CondD=GT, N=1, V=0 -> CondExE=0, PCSrcE=0, BranchTakenE=0; with N=V=0 and Z=0 -> BranchTakenE=1.
- FlushE=1 with RegWriteD=1 and PCSrcD=1 -> next cycle RegWriteE=0, PCSrcE=0, ALUControlE=NOP_CODE, CondExE=1. With COND_SQUASH_COUNT_EN, the count does not increment.
- With COND_SQUASH_COUNT_EN: 3 consecutive CondD=4'hF instructions -> SquashCountE=3.
